// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the data-memory path: funct3 encodings, request
// enable bit positions and the data cache controller state encoding.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  // Controller status as seen by the output/next-state logic and by checkers.
  typedef struct packed {
    state_e state;
    logic   req;
    logic   hit;
  } dcache_status_t;

endpackage

// File: rtl/dcache_align.sv
// Combinational load extraction (byte/half/word with sign or zero extension)
// and store merge of a byte/half/word into a 128-bit cache line.
module dcache_align
  import rv32_mem_pkg::*;
(
  input  logic [3:0]   offset_i,
  input  logic [2:0]   ld_funct3_i,
  input  logic [1:0]   st_funct3_i,
  input  logic [127:0] line_i,
  input  logic [31:0]  st_data_i,
  output logic [31:0]  ld_data_o,
  output logic [127:0] line_o
);

  logic [31:0] word_v;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    word_v = line_i[{offset_i[3:2], 5'b0} +: 32];
    half_v = word_v[{offset_i[1], 4'b0} +: 16];
    byte_v = word_v[{offset_i[1:0], 3'b0} +: 8];
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   ld_data_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  ld_data_o = {24'b0, byte_v};
      F3_LHU:  ld_data_o = {16'b0, half_v};
      default: ld_data_o = word_v;
    endcase
  end

  // Low address bits below the access size are simply dropped.
  always_comb begin
    line_o = line_i;
    case (st_funct3_i)
      F3_SB:   line_o[{offset_i, 3'b0} +: 8]         = st_data_i[7:0];
      F3_SH:   line_o[{offset_i[3:1], 4'b0} +: 16]   = st_data_i[15:0];
      F3_SW:   line_o[{offset_i[3:2], 5'b0} +: 32]   = st_data_i;
      default: line_o = line_i;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache with busywait handshake.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
  import rv32_mem_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   DMEM_READ,
  input  logic [2:0]   DMEM_WRITE,
  input  logic [31:0]  DMEM_ADDR,
  input  logic [31:0]  DMEM_DATA_WRITE,
  output logic [31:0]  DMEM_DATA_READ,
  output logic         BUSYWAIT,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = BLOCK_BYTES * 8;

  logic                 rd_en, wr_en, req;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0]    data_q [LINES];
  logic [LINE_W-1:0]    merged_line;
  logic [31:0]          ld_word;
  state_e               state_q, state_d;
  dcache_status_t       st;
  logic                 fill_en, store_en, miss_evt;

  assign rd_en = DMEM_READ[RD_EN_BIT];
  assign wr_en = DMEM_WRITE[WR_EN_BIT];
  assign idx   = DMEM_ADDR[OFF_W +: IDX_W];
  assign tag   = DMEM_ADDR[31 -: TAG_W];
  // Requests are ignored while reset is held so outputs sit at reset values.
  assign req   = RST && (rd_en || wr_en);
  assign st    = '{state: state_q, req: req,
                   hit: req && valid_q[idx] && (tag_q[idx] == tag)};

  dcache_align u_align (
    .offset_i    (DMEM_ADDR[OFF_W-1:0]),
    .ld_funct3_i (DMEM_READ[2:0]),
    .st_funct3_i (DMEM_WRITE[1:0]),
    .line_i      (data_q[idx]),
    .st_data_i   (DMEM_DATA_WRITE),
    .ld_data_o   (ld_word),
    .line_o      (merged_line)
  );

  always_comb begin
    state_d        = state_q;
    BUSYWAIT       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    DMEM_DATA_READ = '0;
    fill_en        = 1'b0;
    store_en       = 1'b0;
    miss_evt       = 1'b0;
    case (st.state)
      IDLE: begin
        if (st.req && st.hit) begin
          store_en = wr_en;
          if (!wr_en) DMEM_DATA_READ = ld_word;
        end else if (st.req) begin
          BUSYWAIT = 1'b1;
          miss_evt = 1'b1;
          state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[idx], idx};
        mem_writedata = data_q[idx];
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        mem_read    = 1'b1;
        mem_address = DMEM_ADDR[31:OFF_W];
        if (!mem_busywait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_en) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_q[idx] <= mem_readdata;
      tag_q[idx]  <= tag;
    end else if (store_en) begin
      data_q[idx] <= merged_line;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        retry_q;

  // retry_q marks a request that already missed once, so its retry is not a hit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      if (miss_evt) begin
        retry_q <= 1'b1;
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (st.state == IDLE && st.hit) begin
        retry_q <= 1'b0;
        if (!retry_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, randomized traffic
// against a flat byte-memory reference, and a reset-during-fetch sequence.
module tb_dcache;
  import rv32_mem_pkg::*;

  localparam int M     = 3;
  localparam int LINES = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   DMEM_READ;
  logic [2:0]   DMEM_WRITE;
  logic [31:0]  DMEM_ADDR, DMEM_DATA_WRITE, DMEM_DATA_READ;
  logic         BUSYWAIT, mem_read, mem_write, mem_busywait;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  dcache #(.LINES(LINES), .BLOCK_BYTES(16)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .DMEM_READ       (DMEM_READ),
    .DMEM_WRITE      (DMEM_WRITE),
    .DMEM_ADDR       (DMEM_ADDR),
    .DMEM_DATA_WRITE (DMEM_DATA_WRITE),
    .DMEM_DATA_READ  (DMEM_DATA_READ),
    .BUSYWAIT        (BUSYWAIT),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } txn_t;

  logic [127:0] mem_q [256];
  int unsigned  lat_cnt = 0;
  txn_t         txn_q [$];

  assign mem_busywait = (mem_read || mem_write) && (lat_cnt != M - 1);
  assign mem_readdata = mem_q[mem_address[7:0]];

  always @(posedge CLK) begin
    if (mem_read || mem_write) begin
      if (!mem_busywait) begin
        lat_cnt <= 0;
        txn_q.push_back(txn_t'{mem_write, mem_address, mem_write ? mem_writedata : mem_readdata});
        if (mem_write) mem_q[mem_address[7:0]] = mem_writedata;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [4096];
  logic       occ_valid [LINES];
  logic       occ_dirty [LINES];
  int         occ_tag   [LINES];
  int         n_hits_exp, n_miss_exp;

  task automatic sync_ref();
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem_q[i / 16][(i % 16) * 8 +: 8];
    for (int i = 0; i < LINES; i++) begin
      occ_valid[i] = 1'b0;
      occ_dirty[i] = 1'b0;
      occ_tag[i]   = 0;
    end
    n_hits_exp = 0;
    n_miss_exp = 0;
  endtask

  function automatic logic [127:0] ref_block(input int baddr);
    logic [127:0] blk;
    for (int b = 0; b < 16; b++) blk[b * 8 +: 8] = ref_mem[baddr * 16 + b];
    return blk;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    w = {ref_mem[{a[11:2], 2'd3}], ref_mem[{a[11:2], 2'd2}],
         ref_mem[{a[11:2], 2'd1}], ref_mem[{a[11:2], 2'd0}]};
    h = {ref_mem[{a[11:1], 1'b1}], ref_mem[{a[11:1], 1'b0}]};
    b = ref_mem[a[11:0]];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'b0, b};
      F3_LHU:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that
  // completes the access. stall counts cycles seen with BUSYWAIT high.
  task automatic run_op(input logic st, input logic both, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int stall, output logic timeout);
    DMEM_ADDR       = a;
    DMEM_DATA_WRITE = wd;
    DMEM_WRITE      = st ? {1'b1, f3[1:0]} : 3'b000;
    DMEM_READ       = (!st || both) ? {1'b1, f3} : 4'b0000;
    stall   = 0;
    timeout = 1'b0;
    @(negedge CLK);
    while (BUSYWAIT) begin
      stall++;
      if (stall > 50) begin
        timeout = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    rdata = DMEM_DATA_READ;
    @(posedge CLK);
    #1;
    DMEM_READ  = 4'b0;
    DMEM_WRITE = 3'b0;
  endtask

  task automatic do_op(input logic st, input logic both, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output int stall);
    int   idx, tg, exp_stall;
    logic hit, timeout;
    txn_t exp_txn [$];
    idx = int'(a[6:4]);
    tg  = int'(a[31:7]);
    hit = occ_valid[idx] && (occ_tag[idx] == tg);
    exp_txn = {};
    if (hit) begin
      exp_stall = 0;
    end else begin
      if (occ_valid[idx] && occ_dirty[idx]) begin
        exp_txn.push_back(txn_t'{1'b1, 28'(occ_tag[idx] * LINES + idx),
                                 ref_block(occ_tag[idx] * LINES + idx)});
        exp_stall = 2 * M + 1;
      end else begin
        exp_stall = M + 1;
      end
      exp_txn.push_back(txn_t'{1'b0, a[31:4], 128'b0});
    end
    if (!st) exp_q.push_back(ref_load(f3, a));
    txn_q.delete();
    run_op(st, both, f3, a, wd, rdata, stall, timeout);
    if (timeout) begin
      n_checks++;
      $display("FAIL busywait_bound: addr %h still stalled after 50 cycles", a);
    end
    check("stall_cycles", 128'(stall), 128'(exp_stall));
    if (!st) check("load_data", {96'b0, rdata}, {96'b0, exp_q.pop_front()});
    check("mem_txn_count", 128'(txn_q.size()), 128'(exp_txn.size()));
    for (int i = 0; i < exp_txn.size() && i < txn_q.size(); i++) begin
      check("mem_txn_kind_addr", {99'b0, txn_q[i].wr, txn_q[i].addr},
            {99'b0, exp_txn[i].wr, exp_txn[i].addr});
      if (exp_txn[i].wr) check("writeback_block", txn_q[i].data, exp_txn[i].data);
    end
    if (hit) n_hits_exp++;
    else n_miss_exp++;
    if (st) begin
      case (f3[1:0])
        F3_SB: ref_mem[a[11:0]] = wd[7:0];
        F3_SH: begin
          ref_mem[{a[11:1], 1'b0}] = wd[7:0];
          ref_mem[{a[11:1], 1'b1}] = wd[15:8];
        end
        F3_SW: for (int b = 0; b < 4; b++) ref_mem[{a[11:2], 2'(b)}] = wd[b * 8 +: 8];
        default: ;
      endcase
    end
    occ_dirty[idx] = st ? 1'b1 : (hit ? occ_dirty[idx] : 1'b0);
    occ_valid[idx] = 1'b1;
    occ_tag[idx]   = tg;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st;
    logic        both;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  vec_t        vecs [19];
  logic [2:0]  ld_f3s [5];
  logic [31:0] rdata;
  int          stall, waited;
  logic        st_r, both_r;
  logic [2:0]  f3_r;
  logic [31:0] a_r, wd_r;

  initial begin
    RST = 1'b0;
    DMEM_READ = '0; DMEM_WRITE = '0; DMEM_ADDR = '0; DMEM_DATA_WRITE = '0;
    for (int b = 0; b < 256; b++) mem_q[b] = {$urandom, $urandom, $urandom, $urandom};
    mem_q[8'h04] = 128'h44332211_88776655_CCBBAA99_00FFEEDD;
    mem_q[8'h14] = 128'hDEADBEEF_0BADF00D_12345678_CAFEBABE;
    sync_ref();
    ld_f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    vecs[0]  = '{1'b0, 1'b0, F3_LW,          32'h040, 32'h0,        32'h00FFEEDD, M + 1};
    vecs[1]  = '{1'b1, 1'b0, {1'b0, F3_SB},  32'h041, 32'h80,       32'h0,        0};
    vecs[2]  = '{1'b0, 1'b0, F3_LB,          32'h041, 32'h0,        32'hFFFFFF80, 0};
    vecs[3]  = '{1'b0, 1'b0, F3_LBU,         32'h041, 32'h0,        32'h00000080, 0};
    vecs[4]  = '{1'b1, 1'b0, {1'b0, F3_SH},  32'h046, 32'hBEEF,     32'h0,        0};
    vecs[5]  = '{1'b0, 1'b0, F3_LH,          32'h046, 32'h0,        32'hFFFFBEEF, 0};
    vecs[6]  = '{1'b0, 1'b0, F3_LHU,         32'h046, 32'h0,        32'h0000BEEF, 0};
    vecs[7]  = '{1'b0, 1'b0, F3_LW,          32'h044, 32'h0,        32'hBEEFAA99, 0};
    vecs[8]  = '{1'b0, 1'b0, F3_LH,          32'h047, 32'h0,        32'hFFFFBEEF, 0};
    vecs[9]  = '{1'b0, 1'b0, F3_LW,          32'h043, 32'h0,        32'h00FF80DD, 0};
    vecs[10] = '{1'b0, 1'b0, F3_LB,          32'h04B, 32'h0,        32'hFFFFFF88, 0};
    vecs[11] = '{1'b0, 1'b0, F3_LHU,         32'h04A, 32'h0,        32'h00008877, 0};
    vecs[12] = '{1'b0, 1'b0, F3_LB,          32'h04F, 32'h0,        32'h00000044, 0};
    vecs[13] = '{1'b1, 1'b1, {1'b0, F3_SW},  32'h048, 32'h12345678, 32'h0,        0};
    vecs[14] = '{1'b0, 1'b0, F3_LW,          32'h048, 32'h0,        32'h12345678, 0};
    vecs[15] = '{1'b0, 1'b0, F3_LW,          32'h140, 32'h0,        32'hCAFEBABE, 2 * M + 1};
    vecs[16] = '{1'b0, 1'b0, F3_LW,          32'h040, 32'h0,        32'h00FF80DD, M + 1};
    vecs[17] = '{1'b0, 1'b0, F3_LW,          32'h048, 32'h0,        32'h12345678, 0};
    vecs[18] = '{1'b0, 1'b0, F3_LBU,         32'h14F, 32'h0,        32'h000000DE, M + 1};

    // reset state
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("reset_busywait",   {127'b0, BUSYWAIT},      128'b0);
    check("reset_mem_read",   {127'b0, mem_read},      128'b0);
    check("reset_mem_write",  {127'b0, mem_write},     128'b0);
    check("reset_mem_addr",   {100'b0, mem_address},   128'b0);
    check("reset_mem_wdata",  mem_writedata,           128'b0);
    check("reset_data_read",  {96'b0, DMEM_DATA_READ}, 128'b0);
`ifdef DCACHE_STATS_EN
    check("reset_hit_count",  {96'b0, hit_count},  128'b0);
    check("reset_miss_count", {96'b0, miss_count}, 128'b0);
`endif
    @(posedge CLK);
    #1;

    for (int i = 0; i < 19; i++) begin
      do_op(vecs[i].st, vecs[i].both, vecs[i].f3, vecs[i].addr, vecs[i].wd, rdata, stall);
      check("vec_stall", 128'(stall), 128'(vecs[i].exp_stall));
      if (!vecs[i].st) check("vec_data", {96'b0, rdata}, {96'b0, vecs[i].exp_rd});
    end

    // randomized traffic over 24 blocks: three tags compete for each index
    for (int i = 0; i < 300; i++) begin
      a_r    = {20'b0, 12'($urandom_range(0, 24 * 16 - 1))};
      st_r   = ($urandom_range(0, 2) == 0);
      both_r = st_r && ($urandom_range(0, 3) == 0);
      f3_r   = st_r ? {1'b0, 2'($urandom_range(0, 2))} : ld_f3s[$urandom_range(0, 4)];
      wd_r   = $urandom;
      do_op(st_r, both_r, f3_r, a_r, wd_r, rdata, stall);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge CLK);
        check("idle_busywait", {127'b0, BUSYWAIT}, 128'b0);
        check("idle_mem_req",  {126'b0, mem_read, mem_write}, 128'b0);
        @(posedge CLK);
        #1;
      end
    end

`ifdef DCACHE_STATS_EN
    check("hit_count",  {96'b0, hit_count},  128'(n_hits_exp));
    check("miss_count", {96'b0, miss_count}, 128'(n_miss_exp));
`endif

    // reset asserted while the fill is outstanding
    DMEM_ADDR  = 32'h240;
    DMEM_READ  = {1'b1, F3_LW};
    DMEM_WRITE = 3'b0;
    waited = 0;
    @(negedge CLK);
    while (!mem_read && waited < 30) begin
      waited++;
      @(negedge CLK);
    end
    if (!mem_read) begin
      n_checks++;
      $display("FAIL fetch_start: mem_read not seen within 30 cycles");
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_mid_fetch_mem_read",  {127'b0, mem_read},  128'b0);
    check("rst_mid_fetch_mem_write", {127'b0, mem_write}, 128'b0);
    check("rst_mid_fetch_busywait",  {127'b0, BUSYWAIT},  128'b0);
    DMEM_READ = 4'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("post_reset_busywait", {127'b0, BUSYWAIT}, 128'b0);
    @(posedge CLK);
    #1;
    sync_ref();
    // miss, hit, hit, miss
    do_op(1'b0, 1'b0, F3_LW, 32'h240, 32'h0, rdata, stall);
    check("refetch_after_reset", 128'(stall), 128'(M + 1));
    do_op(1'b0, 1'b0, F3_LW, 32'h240, 32'h0, rdata, stall);
    do_op(1'b0, 1'b0, F3_LHU, 32'h24A, 32'h0, rdata, stall);
    do_op(1'b0, 1'b0, F3_LW, 32'h340, 32'h0, rdata, stall);
`ifdef DCACHE_STATS_EN
    check("stats_hit_count",  {96'b0, hit_count},  128'd2);
    check("stats_miss_count", {96'b0, miss_count}, 128'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
